// File: rtl/uart_test_pkg.sv
// Shared encodings for the UART test-pattern generator: pattern modes and FSM states.
package uart_test_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/uart_pattern_core.sv
// Pattern register: loads the per-mode first word and steps to the next word on advance.
module uart_pattern_core
    import uart_test_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1),
    parameter logic [DATA_W-1:0] FIXED_VAL = 8'h55
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  mode_e             load_mode_i,
    input  logic              adv_i,
    input  mode_e             mode_i,
    output logic [DATA_W-1:0] pat_o
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [DATA_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? DATA_W'(1) : LFSR_SEED;

    logic [DATA_W-1:0] pat_q, load_val, adv_val;

    // First word of a run, chosen by the mode presented with the start.
    always_comb begin
        load_val = '0;
        case (load_mode_i)
            MODE_INC:   load_val = '0;
            MODE_LFSR:  load_val = SEED_EFF;
            MODE_WALK:  load_val = DATA_W'(1);
            MODE_CONST: load_val = FIXED_VAL;
            default:    load_val = '0;
        endcase
    end

    // Next word: wrap-around increment, Galois right-shift LFSR, rotate-left walking one, or hold.
    always_comb begin
        adv_val = pat_q;
        case (mode_i)
            MODE_INC:   adv_val = pat_q + DATA_W'(1);
            MODE_LFSR:  adv_val = (pat_q >> 1) ^ (pat_q[0] ? LFSR_TAPS : '0);
            MODE_WALK:  adv_val = {pat_q[DATA_W-2:0], pat_q[DATA_W-1]};
            MODE_CONST: adv_val = pat_q;
            default:    adv_val = pat_q;
        endcase
    end

    // Pattern register; load has priority since it only happens while idle.
    always_ff @(posedge clk_i) begin
        if (rst_i)       pat_q <= '0;
        else if (load_i) pat_q <= load_val;
        else if (adv_i)  pat_q <= adv_val;
    end

    assign pat_o = pat_q;

endmodule

// File: rtl/uart_test_pattern_gen.sv
// Test-data source for a byte sink: interval-spaced words over valid/ready, burst or continuous.
module uart_test_pattern_gen
    import uart_test_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       CNT_W     = 16,
    parameter int unsigned       INTERVAL  = 1017,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1),
    parameter logic [DATA_W-1:0] FIXED_VAL = 8'h55
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  burst_len,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(INTERVAL - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, word_cnt_q, burst_q, word_cnt_inc;
    mode_e            mode_q;
    logic             stop_q;
    logic             start_acc, hs, burst_end;

    assign start_acc    = (state_q == ST_IDLE) && start;
    assign hs           = (state_q == ST_SEND) && data_ready;
    assign word_cnt_inc = word_cnt_q + CNT_W'(1);
    assign burst_end    = (burst_q != '0) && (word_cnt_inc == burst_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: stop in WAIT ends the run at once; in SEND it only takes effect at the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_WAIT;
            ST_WAIT: begin
                if (stop)                    state_d = ST_DONE;
                else if (cnt_q == LAST_IDLE) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs) begin
                    if (burst_end || stop_q || stop) state_d = ST_DONE;
                    else                             state_d = ST_WAIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; the word itself comes straight from the pattern register.
    always_comb begin
        data_valid = (state_q == ST_SEND);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
    end

    // Idle-interval counter restarts on start and on every handshake.
    always_ff @(posedge clk) begin
        if (rst)                    cnt_q <= '0;
        else if (start_acc || hs)   cnt_q <= '0;
        else if (state_q == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);
    end

    // Accepted-word counter; wraps naturally in continuous mode and holds after the run.
    always_ff @(posedge clk) begin
        if (rst)            word_cnt_q <= '0;
        else if (start_acc) word_cnt_q <= '0;
        else if (hs)        word_cnt_q <= word_cnt_inc;
    end

    // Run configuration captured on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_INC;
            burst_q <= '0;
        end else if (start_acc) begin
            mode_q  <= mode_e'(mode);
            burst_q <= burst_len;
        end
    end

    // Remembers a stop raised while a word is pending so it is honoured after that word is taken.
    always_ff @(posedge clk) begin
        if (rst)                                stop_q <= 1'b0;
        else if (start_acc)                     stop_q <= 1'b0;
        else if ((state_q == ST_SEND) && stop)  stop_q <= 1'b1;
    end

    assign word_cnt = word_cnt_q;

    uart_pattern_core #(
        .DATA_W   (DATA_W),
        .LFSR_TAPS(LFSR_TAPS),
        .LFSR_SEED(LFSR_SEED),
        .FIXED_VAL(FIXED_VAL)
    ) u_core (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (start_acc),
        .load_mode_i(mode_e'(mode)),
        .adv_i      (hs),
        .mode_i     (mode_q),
        .pat_o      (data_out)
    );

endmodule

// File: tb/tb_uart_test_pattern_gen.sv
// Randomised self-checking bench for uart_test_pattern_gen against a word-sequence/timing model.
module tb_uart_test_pattern_gen;

    localparam int IV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] burst_len = 16'd0;
    logic        data_ready = 1'b0;
    logic [7:0]  data_out, d0_data_out;
    logic        data_valid, busy, done, d0_valid, d0_busy, d0_done;
    logic [15:0] word_cnt, d0_word_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    uart_test_pattern_gen #(.DATA_W(8), .CNT_W(16), .INTERVAL(IV)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .burst_len(burst_len),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    // Second instance with a zero seed, driven identically, to check the seed fix-up.
    uart_test_pattern_gen #(.DATA_W(8), .CNT_W(16), .INTERVAL(IV), .LFSR_SEED(8'h00)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .burst_len(burst_len),
        .data_out(d0_data_out), .data_valid(d0_valid), .data_ready(data_ready),
        .busy(d0_busy), .done(d0_done), .word_cnt(d0_word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // i-th word of a run (0-based) derived directly from the pattern rules.
    function automatic logic [7:0] model_word(input logic [1:0] m, input int i);
        logic [7:0] v;
        case (m)
            2'd0: model_word = 8'(i % 256);
            2'd1: begin
                v = 8'h01;
                for (int k = 0; k < i; k++) v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
                model_word = v;
            end
            2'd2: model_word = 8'(1 << (i % 8));
            default: model_word = 8'h55;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [15:0] bl);
        mode = m; burst_len = bl; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycles until data_valid, bounded; a timeout shows up as a wrong latency.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!data_valid && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (word_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_wcnt: got %0d want 0", word_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_inc_burst();
        int lat;
        data_ready = 1'b1;
        do_start(2'd0, 16'd3);
        for (int k = 0; k < 3; k++) begin
            wait_valid(lat);
            n_cmp++; if (lat !== IV) begin n_bad++; $display("FAIL inc_latency[%0d]: got %0d want %0d", k, lat, IV); end
            n_cmp++; if (data_out !== model_word(2'd0, k)) begin n_bad++; $display("FAIL inc_data[%0d]: got %h want %h", k, data_out, model_word(2'd0, k)); end
            n_cmp++; if (word_cnt !== 16'(k)) begin n_bad++; $display("FAIL inc_wcnt[%0d]: got %0d want %0d", k, word_cnt, k); end
            tick();
            n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL inc_valid_drop[%0d]: got %b want 0", k, data_valid); end
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL inc_done: got %b want 1", done); end
        n_cmp++; if (word_cnt !== 16'd3) begin n_bad++; $display("FAIL inc_final_wcnt: got %0d want 3", word_cnt); end
        tick();
        n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL inc_idle: got done,busy=%b want 00", {done, busy}); end
        data_ready = 1'b0;
    endtask

    task automatic test_lfsr();
        int lat;
        data_ready = 1'b1;
        do_start(2'd1, 16'd5);
        for (int k = 0; k < 5; k++) begin
            wait_valid(lat);
            n_cmp++; if (lat !== IV) begin n_bad++; $display("FAIL lfsr_latency[%0d]: got %0d want %0d", k, lat, IV); end
            n_cmp++; if (data_out !== model_word(2'd1, k)) begin n_bad++; $display("FAIL lfsr_data[%0d]: got %h want %h", k, data_out, model_word(2'd1, k)); end
            n_cmp++; if (d0_data_out !== model_word(2'd1, k)) begin n_bad++; $display("FAIL lfsr_seed0_data[%0d]: got %h want %h", k, d0_data_out, model_word(2'd1, k)); end
            n_cmp++; if (data_out === 8'h00) begin n_bad++; $display("FAIL lfsr_nonzero[%0d]: got %h want nonzero", k, data_out); end
            tick();
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL lfsr_done: got %b want 1", done); end
        tick();
        data_ready = 1'b0;
    endtask

    task automatic test_walk_const();
        int lat;
        logic [1:0] m;
        int n;
        data_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            m = (c == 0) ? 2'd2 : 2'd3;
            n = (c == 0) ? 9 : 4;
            do_start(m, 16'(n));
            for (int k = 0; k < n; k++) begin
                wait_valid(lat);
                n_cmp++; if (data_out !== model_word(m, k)) begin n_bad++; $display("FAIL pat_data[m%0d,%0d]: got %h want %h", m, k, data_out, model_word(m, k)); end
                tick();
            end
            n_cmp++; if ({done, word_cnt} !== {1'b1, 16'(n)}) begin n_bad++; $display("FAIL pat_done[m%0d]: got done=%b wcnt=%0d want 1/%0d", m, done, word_cnt, n); end
            tick();
        end
        data_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat, bad;
        logic [7:0] held;
        data_ready = 1'b0;
        do_start(2'd0, 16'd2);
        wait_valid(lat);
        n_cmp++; if (lat !== IV) begin n_bad++; $display("FAIL bp_latency: got %0d want %0d", lat, IV); end
        held = data_out;
        bad = 0;
        repeat (20) begin
            tick();
            if (data_valid !== 1'b1 || data_out !== held) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
        n_cmp++; if (held !== 8'h00) begin n_bad++; $display("FAIL bp_data0: got %h want 00", held); end
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        n_cmp++; if ({data_valid, word_cnt} !== {1'b0, 16'd1}) begin n_bad++; $display("FAIL bp_accept: got valid=%b wcnt=%0d want 0/1", data_valid, word_cnt); end
        wait_valid(lat);
        n_cmp++; if (lat !== IV) begin n_bad++; $display("FAIL bp_next_latency: got %0d want %0d", lat, IV); end
        n_cmp++; if (data_out !== 8'h01) begin n_bad++; $display("FAIL bp_data1: got %h want 01", data_out); end
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        n_cmp++; if ({done, word_cnt} !== {1'b1, 16'd2}) begin n_bad++; $display("FAIL bp_done: got done=%b wcnt=%0d want 1/2", done, word_cnt); end
        tick();
    endtask

    task automatic test_stop();
        int lat, seen;
        logic [7:0] held;
        // stop while waiting
        data_ready = 1'b1;
        do_start(2'd0, 16'd0);
        tick(); tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++; if ({done, data_valid} !== 2'b10) begin n_bad++; $display("FAIL stopwait_done: got done,valid=%b want 10", {done, data_valid}); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL stopwait_idle: got busy,done=%b want 00", {busy, done}); end
        seen = 0;
        repeat (3 * IV) begin tick(); if (data_valid) seen++; end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL stopwait_novalid: got %0d valid cycles want 0", seen); end
        // stop while a word is pending
        data_ready = 1'b0;
        do_start(2'd2, 16'd0);
        wait_valid(lat);
        held = data_out;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({data_valid, busy, data_out} !== {2'b11, held}) begin n_bad++; $display("FAIL stopsend_hold: got valid=%b busy=%b data=%h want 1/1/%h", data_valid, busy, data_out, held); end
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        n_cmp++; if ({done, data_valid, word_cnt} !== {2'b10, 16'd1}) begin n_bad++; $display("FAIL stopsend_done: got done=%b valid=%b wcnt=%0d want 1/0/1", done, data_valid, word_cnt); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stopsend_idle: got busy=%b want 0", busy); end
        // start during a run is ignored
        data_ready = 1'b1;
        do_start(2'd0, 16'd2);
        tick();
        mode = 2'd3; burst_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(lat);
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL restart_ignored0: got %h want 00", data_out); end
        tick();
        wait_valid(lat);
        n_cmp++; if (data_out !== 8'h01) begin n_bad++; $display("FAIL restart_ignored1: got %h want 01", data_out); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart_burst_done: got %b want 1", done); end
        tick();
        data_ready = 1'b0;
    endtask

    task automatic test_continuous();
        int lat;
        data_ready = 1'b1;
        do_start(2'd0, 16'd0);
        for (int i = 0; i < 300; i++) begin
            wait_valid(lat);
            n_cmp++; if ({lat, data_out, word_cnt} !== {IV, model_word(2'd0, i), 16'(i)}) begin
                n_bad++;
                $display("FAIL cont_word[%0d]: got lat=%0d data=%h wcnt=%0d want %0d/%h/%0d", i, lat, data_out, word_cnt, IV, model_word(2'd0, i), i);
            end
            tick();
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cont_busy: got %b want 1", busy); end
        data_ready = 1'b0;
        wait_valid(lat);
        rst = 1'b1;
        tick();
        n_cmp++; if ({data_out, data_valid, busy, done, word_cnt} !== 27'd0) begin n_bad++; $display("FAIL midrun_rst: got data=%h valid=%b busy=%b done=%b wcnt=%0d want all 0", data_out, data_valid, busy, done, word_cnt); end
        rst = 1'b0;
        tick();
        n_cmp++; if ({done, busy, data_valid} !== 3'b000) begin n_bad++; $display("FAIL midrun_nodone: got done,busy,valid=%b want 000", {done, busy, data_valid}); end
    endtask

    task automatic test_random();
        int lat, d, bad, bl;
        logic [1:0] m;
        logic [7:0] held;
        repeat (6) begin
            m  = 2'($urandom_range(0, 3));
            bl = int'($urandom_range(1, 6));
            data_ready = 1'b0;
            do_start(m, 16'(bl));
            for (int k = 0; k < bl; k++) begin
                wait_valid(lat);
                n_cmp++; if ({lat, data_out} !== {IV, model_word(m, k)}) begin n_bad++; $display("FAIL rand_word[m%0d,%0d]: got lat=%0d data=%h want %0d/%h", m, k, lat, data_out, IV, model_word(m, k)); end
                held = data_out;
                d = int'($urandom_range(0, 4));
                bad = 0;
                repeat (d) begin tick(); if (data_valid !== 1'b1 || data_out !== held) bad++; end
                n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rand_hold[m%0d,%0d]: got %0d unstable want 0", m, k, bad); end
                data_ready = 1'b1;
                tick();
                data_ready = 1'b0;
            end
            n_cmp++; if ({done, word_cnt} !== {1'b1, 16'(bl)}) begin n_bad++; $display("FAIL rand_done[m%0d]: got done=%b wcnt=%0d want 1/%0d", m, done, word_cnt, bl); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_inc_burst();
        test_lfsr();
        test_walk_const();
        test_backpressure();
        test_stop();
        test_continuous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
